// File: rtl/iec_fast_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iec_fast_host : host-side IEC fast serial burst engine (FCLK bit clock, MSB first)
// Revision 1.0
// ----------------------------------------------------------------------------
module iec_fast_host #(
  parameter int RX_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       dir,
  input  logic [7:0] rate,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic       iec_data_in,
  input  logic       iec_fclk_in,
  output logic       iec_data_out,
  output logic       iec_fclk_out
);

  localparam int TW = (RX_TIMEOUT < 2) ? 1 : $clog2(RX_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} tx_state_t;

  tx_state_t     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    period_q, period_d;
  logic [7:0]    tick_q, tick_d;
  logic [2:0]    tx_cnt_q, tx_cnt_d;
  logic          fclk_out_q, fclk_out_d;
  logic          data_out_q, data_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [2:0]    fclk_sync_q, fclk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [6:0]    rx_shift_q, rx_shift_d;
  logic [2:0]    rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] rx_timer_q, rx_timer_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;

  logic          fclk_rise;
  logic          rx_active;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    period_d   = period_q;
    tick_d     = tick_q;
    tx_cnt_d   = tx_cnt_q;
    fclk_out_d = fclk_out_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start && dir) begin
          shift_d    = tx_data;
          period_d   = rate;
          tick_d     = 8'd0;
          tx_cnt_d   = 3'd7;
          state_d    = ST_LOW;
          fclk_out_d = 1'b0;
          data_out_d = tx_data[7];
          busy_d     = 1'b1;
        end
      end
      ST_LOW: begin
        if (ce) begin
          if (tick_q == period_q) begin
            tick_d     = 8'd0;
            state_d    = ST_HIGH;
            fclk_out_d = 1'b1;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      ST_HIGH: begin
        if (ce) begin
          if (tick_q == period_q) begin
            tick_d = 8'd0;
            if (tx_cnt_q != 3'd0) begin
              shift_d    = {shift_q[6:0], 1'b0};
              tx_cnt_d   = tx_cnt_q - 3'd1;
              state_d    = ST_LOW;
              fclk_out_d = 1'b0;
              data_out_d = shift_q[6];
            end else begin
              state_d    = ST_IDLE;
              fclk_out_d = 1'b1;
              data_out_d = 1'b1;
              busy_d     = 1'b0;
              done_d     = 1'b1;
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping dir mid-byte abandons the transfer silently.
    if (!dir && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      fclk_out_d = 1'b1;
      data_out_d = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign fclk_rise = fclk_sync_q[1] && !fclk_sync_q[2];
  assign rx_active = !dir && (state_q == ST_IDLE);

  always_comb begin
    fclk_sync_d = {fclk_sync_q[1:0], iec_fclk_in};
    data_sync_d = {data_sync_q[0], iec_data_in};
    rx_shift_d  = rx_shift_q;
    rx_cnt_d    = rx_cnt_q;
    rx_timer_d  = rx_timer_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    if (dir) begin
      rx_cnt_d   = 3'd0;
      rx_timer_d = '0;
    end else if (rx_active) begin
      // An edge takes priority over a coincident timeout.
      if (fclk_rise) begin
        rx_shift_d = {rx_shift_q[5:0], data_sync_q[1]};
        rx_timer_d = '0;
        if (rx_cnt_q == 3'd7) begin
          rx_data_d  = {rx_shift_q, data_sync_q[1]};
          rx_valid_d = 1'b1;
          rx_cnt_d   = 3'd0;
        end else begin
          rx_cnt_d = rx_cnt_q + 3'd1;
        end
      end else if (ce && rx_cnt_q != 3'd0) begin
        if (rx_timer_q == TW'(RX_TIMEOUT - 1)) begin
          rx_cnt_d   = 3'd0;
          rx_timer_d = '0;
          rx_err_d   = 1'b1;
        end else begin
          rx_timer_d = rx_timer_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'd0;
      period_q    <= 8'd0;
      tick_q      <= 8'd0;
      tx_cnt_q    <= 3'd0;
      fclk_out_q  <= 1'b1;
      data_out_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fclk_sync_q <= 3'b111;
      data_sync_q <= 2'b11;
      rx_shift_q  <= 7'd0;
      rx_cnt_q    <= 3'd0;
      rx_timer_q  <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      period_q    <= period_d;
      tick_q      <= tick_d;
      tx_cnt_q    <= tx_cnt_d;
      fclk_out_q  <= fclk_out_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fclk_sync_q <= fclk_sync_d;
      data_sync_q <= data_sync_d;
      rx_shift_q  <= rx_shift_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_timer_q  <= rx_timer_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign iec_fclk_out = fclk_out_q;
  assign iec_data_out = data_out_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_err       = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_iec_fast_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_iec_fast_host : self-checking bench for the IEC fast serial host engine
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_iec_fast_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       dir;
  logic [7:0] rate;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       iec_data_in;
  logic       iec_fclk_in;
  logic       iec_data_out;
  logic       iec_fclk_out;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [7:0] last_rx;

  typedef struct {
    logic [7:0] data;
    logic [7:0] rate;
    bit         rnd_ce;
    bit         inject;
    int         exp_ticks;
  } tx_vec_t;

  tx_vec_t tbl [6];

  iec_fast_host #(.RX_TIMEOUT(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .dir          (dir),
    .rate         (rate),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err),
    .iec_data_in  (iec_data_in),
    .iec_fclk_in  (iec_fclk_in),
    .iec_data_out (iec_data_out),
    .iec_fclk_out (iec_fclk_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (rx_valid) valid_cnt++;
    if (rx_err)   err_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: after n counted ce ticks, phase = n/P alternates low/high, bit = n/(2P).
  task automatic send_check(input logic [7:0] d, input logic [7:0] r, input bit rnd_ce,
                            input bit inject, input int exp_ticks);
    int n, cyc, p, l, nb, d0;
    bit cev;
    logic prev_fclk;
    logic [7:0] seen;
    p = int'(r) + 1;
    l = 16 * p;
    d0 = done_cnt;
    dir = 1'b1;
    tx_data = d;
    rate = r;
    tx_start = 1'b1;
    ce = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    tx_start = 1'b0;
    tx_data = ~d;
    rate = ~r;
    n = 0;
    nb = 0;
    seen = 8'h00;
    cyc = 0;
    check("tx_accept_busy", 32'(tx_busy), 32'd1);
    check("tx_accept_fclk", 32'(iec_fclk_out), 32'd0);
    check("tx_accept_data", 32'(iec_data_out), 32'(d[7]));
    prev_fclk = iec_fclk_out;
    while (n < l && cyc < 20000) begin
      cev = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      ce = cev;
      tx_start = (inject && cyc == 5) ? 1'b1 : 1'b0;
      step();
      cyc++;
      if (cev) n++;
      if (!prev_fclk && iec_fclk_out) begin
        seen = {seen[6:0], iec_data_out};
        nb++;
      end
      prev_fclk = iec_fclk_out;
      if (n < l) begin
        check("tx_busy", 32'(tx_busy), 32'd1);
        check("tx_fclk", 32'(iec_fclk_out), 32'((n / p) % 2));
        check("tx_data_bit", 32'(iec_data_out), 32'(d[7 - n / (2 * p)]));
        check("tx_done_early", 32'(tx_done), 32'd0);
      end else begin
        check("tx_end_busy", 32'(tx_busy), 32'd0);
        check("tx_end_done", 32'(tx_done), 32'd1);
        check("tx_end_fclk", 32'(iec_fclk_out), 32'd1);
        check("tx_end_data", 32'(iec_data_out), 32'd1);
      end
    end
    tx_start = 1'b0;
    ce = 1'b1;
    check("tx_ticks", 32'(n), 32'(exp_ticks));
    check("tx_rise_count", 32'(nb), 32'd8);
    check("tx_bits_at_rise", 32'(seen), 32'(d));
    step();
    check("tx_after_busy", 32'(tx_busy), 32'd0);
    check("tx_done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic drive_bits(input logic [7:0] b, input int nbits, input bit rnd);
    for (int i = 0; i < nbits; i++) begin
      if (rnd) ce = 1'($urandom_range(0, 1));
      iec_data_in = b[7 - i];
      iec_fclk_in = 1'b0;
      repeat (rnd ? int'($urandom_range(2, 5)) : 3) @(posedge clk);
      #1;
      iec_fclk_in = 1'b1;
      repeat (rnd ? int'($urandom_range(2, 5)) : 3) @(posedge clk);
      #1;
    end
    ce = 1'b1;
  endtask

  task automatic rx_byte_check(input logic [7:0] b, input bit rnd);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    dir = 1'b0;
    drive_bits(b, 8, rnd);
    repeat (4) step();
    check("rx_valid_once", 32'(valid_cnt - v0), 32'd1);
    check("rx_data", 32'(rx_data), 32'(b));
    check("rx_no_err", 32'(err_cnt - e0), 32'd0);
    last_rx = b;
  endtask

  initial begin
    int v0, e0, d0;
    logic [7:0] rb, rr;

    tbl[0] = '{data: 8'hA5, rate: 8'd3, rnd_ce: 1'b0, inject: 1'b0, exp_ticks: 64};
    tbl[1] = '{data: 8'h00, rate: 8'd0, rnd_ce: 1'b0, inject: 1'b0, exp_ticks: 16};
    tbl[2] = '{data: 8'hFF, rate: 8'd0, rnd_ce: 1'b1, inject: 1'b0, exp_ticks: 16};
    tbl[3] = '{data: 8'h81, rate: 8'd1, rnd_ce: 1'b1, inject: 1'b0, exp_ticks: 32};
    tbl[4] = '{data: 8'h3C, rate: 8'd2, rnd_ce: 1'b0, inject: 1'b1, exp_ticks: 48};
    tbl[5] = '{data: 8'h5A, rate: 8'd0, rnd_ce: 1'b1, inject: 1'b1, exp_ticks: 16};

    reset = 1'b1;
    ce = 1'b1;
    dir = 1'b0;
    rate = 8'd0;
    tx_data = 8'h00;
    tx_start = 1'b0;
    iec_data_in = 1'b1;
    iec_fclk_in = 1'b1;
    last_rx = 8'h00;
    repeat (3) step();
    check("rst_fclk", 32'(iec_fclk_out), 32'd1);
    check("rst_data", 32'(iec_data_out), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_err", 32'(rx_err), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    reset = 1'b0;
    step();

    // Receive 8'h3C with exact latency from the 8th raw FCLK rise.
    drive_bits(8'h3C, 7, 1'b0);
    iec_data_in = 1'b0;
    iec_fclk_in = 1'b0;
    repeat (3) step();
    v0 = valid_cnt;
    iec_fclk_in = 1'b1;
    step();
    check("rx_lat_e1", 32'(rx_valid), 32'd0);
    step();
    check("rx_lat_e2", 32'(rx_valid), 32'd0);
    step();
    check("rx_lat_e3", 32'(rx_valid), 32'd1);
    check("rx_lat_data", 32'(rx_data), 32'h3C);
    step();
    check("rx_lat_e4", 32'(rx_valid), 32'd0);
    check("rx_3c_once", 32'(valid_cnt - v0), 32'd1);

    // Partial byte then timeout, then a full byte.
    v0 = valid_cnt;
    e0 = err_cnt;
    drive_bits(8'hA0, 3, 1'b0);
    repeat (247) step();
    check("rx_to_not_yet", 32'(err_cnt - e0), 32'd0);
    repeat (20) step();
    check("rx_to_err", 32'(err_cnt - e0), 32'd1);
    repeat (300) step();
    check("rx_to_single", 32'(err_cnt - e0), 32'd1);
    check("rx_to_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("rx_to_data_kept", 32'(rx_data), 32'h3C);
    rx_byte_check(8'hFF, 1'b0);

    // dir=1 discards a partial receive byte.
    drive_bits(8'hE0, 3, 1'b0);
    dir = 1'b1;
    repeat (3) step();
    dir = 1'b0;
    step();
    rx_byte_check(8'h4B, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      rx_byte_check(rb, 1'b1);
    end

    for (int i = 0; i < 6; i++)
      send_check(tbl[i].data, tbl[i].rate, tbl[i].rnd_ce, tbl[i].inject, tbl[i].exp_ticks);

    // Abort 8'h81 after four bits by dropping dir.
    d0 = done_cnt;
    dir = 1'b1;
    tx_data = 8'h81;
    rate = 8'd1;
    tx_start = 1'b1;
    ce = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (16) step();
    check("abort_pre_busy", 32'(tx_busy), 32'd1);
    check("abort_pre_fclk", 32'(iec_fclk_out), 32'd0);
    dir = 1'b0;
    step();
    check("abort_fclk", 32'(iec_fclk_out), 32'd1);
    check("abort_data", 32'(iec_data_out), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_done", 32'(tx_done), 32'd0);
    repeat (5) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    send_check(8'h81, 8'd1, 1'b0, 1'b0, 32);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      rr = 8'($urandom_range(0, 5));
      send_check(rb, rr, 1'b1, 1'($urandom_range(0, 1)), 16 * (int'(rr) + 1));
    end

    check("rx_hold_during_tx", 32'(rx_data), 32'(last_rx));

    // Reset mid-transfer with tx_start held through release.
    dir = 1'b1;
    tx_data = 8'hC3;
    rate = 8'd2;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (10) step();
    check("rstmid_pre_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'h5A;
    step();
    check("rstmid_fclk", 32'(iec_fclk_out), 32'd1);
    check("rstmid_data", 32'(iec_data_out), 32'd1);
    check("rstmid_busy", 32'(tx_busy), 32'd0);
    check("rstmid_done", 32'(tx_done), 32'd0);
    check("rstmid_rx_data", 32'(rx_data), 32'h00);
    step();
    reset = 1'b0;
    step();
    check("rstrel_busy", 32'(tx_busy), 32'd1);
    check("rstrel_fclk", 32'(iec_fclk_out), 32'd0);
    check("rstrel_data", 32'(iec_data_out), 32'd0);
    tx_start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 200 && tx_busy; i++) step();
    step();
    check("rstrel_drain", 32'(tx_busy), 32'd0);
    check("rstrel_done_once", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
